// File: rtl/alien_bomb_controller.sv
// ---------------------------------------------------------------------------
// alien_bomb_controller
// Drops one bomb at a time from the lowest living alien in a pseudo-randomly
// chosen column. The bomb falls once per frame in 1/64-pixel fixed point and
// is retired on collision or when it reaches the bottom boundary.
//
// Ports
//   clk, resetN        : clock, asynchronous active-low reset
//   startOfFrame       : one-clk pulse per video frame
//   playGame           : game active; low clears the block on the next edge
//   bombCollision      : bomb hit the player or a shield (FALLING only)
//   alienGridX/Y       : formation top-left position in px (signed)
//   aliensAlive        : alive mask, bit = row*ALIEN_COLS + col, row 0 on top
//   topLeftX/Y         : bomb top-left position in px (signed)
//   alive              : bomb in flight (drawing enable)
//   fireEvent          : one-clk pulse when a bomb spawns
//   o_dbgState         : current FSM state, for observation only
//
// Handshake: there is no valid/ready pair here; startOfFrame and
// bombCollision are single-cycle qualifiers sampled on the rising clk edge.
// ---------------------------------------------------------------------------
module alien_bomb_controller #(
   parameter int          BOMB_Y_SPEED    = 192,
   parameter int          COOLDOWN_FRAMES = 45,
   parameter int          ALIEN_COLS      = 8,
   parameter int          ALIEN_ROWS      = 4,
   parameter int          SPACING_X       = 64,
   parameter int          SPACING_Y       = 48,
   parameter int          ALIEN_W         = 32,
   parameter int          ALIEN_H         = 32,
   parameter int          BOTTOM_Y        = 460,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               playGame,
   input  logic               bombCollision,
   input  logic signed [10:0] alienGridX,
   input  logic signed [10:0] alienGridY,
   input  logic [31:0]        aliensAlive,
   output logic signed [10:0] topLeftX,
   output logic signed [10:0] topLeftY,
   output logic               alive,
   output logic               fireEvent,
   output logic [2:0]         o_dbgState
);

   localparam int COL_W = $clog2(ALIEN_COLS);
   localparam int ROW_W = $clog2(ALIEN_ROWS);
   localparam int IDX_W = $clog2(ALIEN_COLS * ALIEN_ROWS);
   localparam int CNT_W = $clog2(COOLDOWN_FRAMES + 1);

   localparam logic [CNT_W-1:0] COOL_RELOAD = CNT_W'(COOLDOWN_FRAMES);
   localparam logic [COL_W-1:0] COL_LAST    = COL_W'(ALIEN_COLS - 1);
   localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(ALIEN_ROWS - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COOLDOWN = 3'd1,
      ST_SELECT   = 3'd2,
      ST_SPAWN    = 3'd3,
      ST_FALLING  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [15:0]         r_lfsr;
   logic [CNT_W-1:0]    r_cool;
   logic [COL_W-1:0]    r_col;
   logic [ROW_W-1:0]    r_row;
   logic [COL_W-1:0]    r_tries;
   logic signed [31:0]  r_x;
   logic signed [31:0]  r_y;
   logic                r_alive;
   logic                r_fire;

   logic [IDX_W-1:0]    w_bit_idx;
   logic                w_hit;
   logic [COL_W-1:0]    w_lfsr_col;
   logic [COL_W-1:0]    w_col_next;
   logic                w_scan_exhausted;
   logic                w_at_bottom;
   logic signed [31:0]  w_spawn_x;
   logic signed [31:0]  w_spawn_y;
   logic                w_unused_x;

   // Scan cursor: current (row, col) into the alive mask.
   assign w_bit_idx        = IDX_W'(32'(r_row) * ALIEN_COLS) + IDX_W'(r_col);
   assign w_hit            = aliensAlive[w_bit_idx];
   assign w_lfsr_col       = COL_W'(32'(r_lfsr) % ALIEN_COLS);
   assign w_col_next       = (r_col == COL_LAST) ? '0 : r_col + 1'b1;
   // Row 0 missed on the last column still to try: give up this round.
   assign w_scan_exhausted = (r_row == '0) && (r_tries == COL_LAST);
   // Integer part of Y >= BOTTOM_Y is the same as fixed-point Y >= BOTTOM_Y*64.
   assign w_at_bottom      = (r_y >= BOTTOM_Y * 64);

   assign w_spawn_x = (32'(alienGridX) + $signed(32'(r_col)) * SPACING_X
                       + ALIEN_W / 2) * 64;
   assign w_spawn_y = (32'(alienGridY) + $signed(32'(r_row)) * SPACING_Y
                       + ALIEN_H) * 64;

   assign topLeftX   = r_x[16:6];
   assign topLeftY   = r_y[16:6];
   assign alive      = r_alive;
   assign fireEvent  = r_fire;
   assign o_dbgState = r_state;
   assign w_unused_x = ^{r_x[31:17], r_x[5:0]};

   // Galois LFSR runs regardless of playGame so column choice keeps moving.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         r_lfsr <= LFSR_SEED;
      else
         r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:     if (playGame) w_next_state = ST_COOLDOWN;
         ST_COOLDOWN: if ((r_cool == '0) && (aliensAlive != '0))
                         w_next_state = ST_SELECT;
         ST_SELECT: begin
            if (w_hit)
               w_next_state = ST_SPAWN;
            else if (w_scan_exhausted)
               w_next_state = ST_COOLDOWN;
         end
         ST_SPAWN:    w_next_state = ST_FALLING;
         ST_FALLING:  if (bombCollision || w_at_bottom)
                         w_next_state = ST_COOLDOWN;
         default:     w_next_state = ST_IDLE;
      endcase
      if (!playGame)
         w_next_state = ST_IDLE;
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_cool  <= COOL_RELOAD;
         r_col   <= '0;
         r_row   <= '0;
         r_tries <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_alive <= 1'b0;
         r_fire  <= 1'b0;
      end else if (!playGame) begin
         r_cool  <= COOL_RELOAD;
         r_col   <= '0;
         r_row   <= '0;
         r_tries <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_alive <= 1'b0;
         r_fire  <= 1'b0;
      end else begin
         r_fire <= 1'b0;
         case (r_state)
            ST_COOLDOWN: begin
               if (w_next_state == ST_SELECT) begin
                  r_col   <= w_lfsr_col;
                  r_row   <= ROW_LAST;
                  r_tries <= '0;
               end else if (startOfFrame && (r_cool != '0)) begin
                  r_cool <= r_cool - 1'b1;
               end
            end
            ST_SELECT: begin
               // On a hit col/row simply hold; SPAWN uses them next clk.
               if (!w_hit) begin
                  if (r_row == '0) begin
                     r_row   <= ROW_LAST;
                     r_col   <= w_col_next;
                     r_tries <= r_tries + 1'b1;
                     if (w_scan_exhausted)
                        r_cool <= COOL_RELOAD;
                  end else begin
                     r_row <= r_row - 1'b1;
                  end
               end
            end
            ST_SPAWN: begin
               r_x     <= w_spawn_x;
               r_y     <= w_spawn_y;
               r_alive <= 1'b1;
               r_fire  <= 1'b1;
            end
            ST_FALLING: begin
               // Collision beats the frame step: Y is frozen where it was hit.
               if (bombCollision || w_at_bottom) begin
                  r_alive <= 1'b0;
                  r_cool  <= COOL_RELOAD;
               end else if (startOfFrame) begin
                  r_y <= r_y + BOMB_Y_SPEED;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
